// File: rtl/mems_pkg.sv
// Shared constants for the MEMS mirror DAC path: word width, SPI timing
// defaults and the DAC command words used to bring the converter up.
package mems_pkg;

  localparam int MEMS_DAC_W      = 24;
  localparam int MEMS_CLK_DIV    = 4;
  localparam int MEMS_GAP_CYCLES = 2;

  // DAC command words (soft reset, internal reference enable)
  localparam logic [23:0] DAC_CMD_SOFT_RESET = 24'h280001;
  localparam logic [23:0] DAC_CMD_VREF_INT   = 24'h380000;

  // Width of a down-counter that must hold values up to max(a,b)-1.
  // Never narrower than one bit so the divide-by-one case still has a counter.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/mems_dac_spi.sv
// SPI transmitter for the MEMS mirror DAC. Accepts one command word per
// start pulse and shifts it MSB-first on SYNC_n/SCLK/MOSI, holding busy
// until the frame and the inter-frame gap have completed.
module mems_dac_spi
  import mems_pkg::*;
#(
  parameter int DATA_W     = MEMS_DAC_W,
  parameter int CLK_DIV    = MEMS_CLK_DIV,
  parameter int GAP_CYCLES = MEMS_GAP_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              done,
  output logic              spi_sync_n,
  output logic              spi_sclk,
  output logic              spi_mosi
);

  localparam int CNT_W = cnt_width(CLK_DIV, GAP_CYCLES);
  localparam int BIT_W = $clog2(DATA_W) + 1;

  localparam logic [CNT_W-1:0] DIV_RELOAD = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_RELOAD = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [BIT_W-1:0] BIT_ONE    = BIT_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_W);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;     // phase counter, counts down to zero
  logic [BIT_W-1:0]    bit_q;     // SCLK falling edges issued in this frame
  logic [DATA_W-1:0]   shreg_q;   // current bit always sits at the MSB
  logic                busy_q;
  logic                done_q;
  logic                sync_n_q;
  logic                sclk_q;
  logic                mosi_q;

  // Frame sequencer: phase timing, bit shifting and all registered bus outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= CNT_ZERO;
      bit_q    <= '0;
      shreg_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sync_n_q <= 1'b1;
      sclk_q   <= 1'b1;
      mosi_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            shreg_q  <= data_in;
            busy_q   <= 1'b1;
            sync_n_q <= 1'b0;
            mosi_q   <= data_in[DATA_W-1];
            cnt_q    <= DIV_RELOAD;
            state_q  <= ST_SETUP;
          end
        end

        // SYNC_n low, SCLK still high: DAC setup time before the first fall
        ST_SETUP: begin
          if (cnt_q == CNT_ZERO) begin
            sclk_q  <= 1'b0;
            bit_q   <= BIT_ONE;
            cnt_q   <= DIV_RELOAD;
            state_q <= ST_SHIFT;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end

        // Low phase ends with a rising edge that advances MOSI; high phase
        // ends with the next falling edge or, after the last bit, HOLD.
        ST_SHIFT: begin
          if (cnt_q != CNT_ZERO) begin
            cnt_q <= cnt_q - CNT_ONE;
          end else if (!sclk_q) begin
            sclk_q  <= 1'b1;
            mosi_q  <= shreg_q[DATA_W-2];
            shreg_q <= {shreg_q[DATA_W-2:0], 1'b0};
            cnt_q   <= DIV_RELOAD;
          end else if (bit_q == BIT_LAST) begin
            cnt_q   <= DIV_RELOAD;
            state_q <= ST_HOLD;
          end else begin
            sclk_q <= 1'b0;
            bit_q  <= bit_q + BIT_ONE;
            cnt_q  <= DIV_RELOAD;
          end
        end

        // SYNC_n held low after the last bit, then the frame is closed
        ST_HOLD: begin
          if (cnt_q == CNT_ZERO) begin
            sync_n_q <= 1'b1;
            mosi_q   <= 1'b0;
            cnt_q    <= GAP_RELOAD;
            state_q  <= ST_GAP;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end

        // Minimum SYNC_n-high time before another frame may begin
        ST_GAP: begin
          if (cnt_q == CNT_ZERO) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end

        // Unreachable encodings: park the bus in its idle levels
        default: begin
          state_q  <= ST_IDLE;
          cnt_q    <= CNT_ZERO;
          busy_q   <= 1'b0;
          sync_n_q <= 1'b1;
          sclk_q   <= 1'b1;
          mosi_q   <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign spi_sync_n = sync_n_q;
  assign spi_sclk   = sclk_q;
  assign spi_mosi   = mosi_q;

endmodule

// File: tb/tb_mems_dac_spi.sv
// Self-checking bench for mems_dac_spi: a default-parameter instance and a
// CLK_DIV=1/GAP_CYCLES=1 instance, each watched by a pin-level bus model.
module tb_mems_dac_spi;
  import mems_pkg::*;

  localparam int W     = MEMS_DAC_W;
  localparam int CLK_P = 10;
  localparam int NVEC  = 12;

  logic clk = 1'b0;
  logic rst;
  logic start0, start1;
  logic [W-1:0] data0, data1;
  logic busy0, done0, sync0, sclk0, mosi0;
  logic busy1, done1, sync1, sclk1, mosi1;

  int total = 0;
  int bad   = 0;

  always #(CLK_P/2) clk = ~clk;

  mems_dac_spi u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .data_in(data0),
    .busy(busy0), .done(done0), .spi_sync_n(sync0), .spi_sclk(sclk0), .spi_mosi(mosi0)
  );

  mems_dac_spi #(.DATA_W(W), .CLK_DIV(1), .GAP_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .data_in(data1),
    .busy(busy1), .done(done1), .spi_sync_n(sync1), .spi_sclk(sclk1), .spi_mosi(mosi1)
  );

  // ---------------- bus model: what the DAC would latch ----------------
  logic [1:0] sync_v, sclk_v, mosi_v;
  assign sync_v = {sync1, sync0};
  assign sclk_v = {sclk1, sclk0};
  assign mosi_v = {mosi1, mosi0};

  logic [W-1:0] acc [2];
  logic [W-1:0] last_word [2];
  int     nb [2];
  int     last_bits [2];
  int     frames [2];
  int     gap_seen [2];
  longint t_rise [2];
  longint t_fall [2];
  longint t_fall_prev [2];
  bit     p_sync [2];
  bit     p_sclk [2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (p_sync[i] && !sync_v[i]) begin
        acc[i]      <= '0;
        nb[i]       <= 0;
        gap_seen[i] <= int'(($time - t_rise[i]) / CLK_P);
      end
      if (!sync_v[i] && p_sclk[i] && !sclk_v[i]) begin
        acc[i]         <= {acc[i][W-2:0], mosi_v[i]};
        nb[i]          <= nb[i] + 1;
        t_fall_prev[i] <= t_fall[i];
        t_fall[i]      <= $time;
      end
      if (!p_sync[i] && sync_v[i]) begin
        last_word[i] <= acc[i];
        last_bits[i] <= nb[i];
        frames[i]    <= frames[i] + 1;
        t_rise[i]    <= $time;
      end
      p_sync[i] <= sync_v[i];
      p_sclk[i] <= sclk_v[i];
    end
  end

  // ---------------- reference model ----------------
  function automatic int cd_of(input bit sel);
    return sel ? 1 : MEMS_CLK_DIV;
  endfunction

  function automatic int gap_of(input bit sel);
    return sel ? 1 : MEMS_GAP_CYCLES;
  endfunction

  // A frame is SETUP + one low/high pair per bit + HOLD, then the gap
  function automatic int model_busy(input bit sel);
    return 2 * cd_of(sel) * (W + 1) + gap_of(sel);
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_true(input string nm, input bit cond, input longint val);
    total++;
    if (!cond) begin
      bad++;
      $display("FAIL %s: value %0d outside required range", nm, val);
    end
  endtask

  task automatic chk_idle(input string nm, input bit sel);
    chk({nm, "_sync_n"}, sel ? sync1 : sync0, 1);
    chk({nm, "_sclk"},   sel ? sclk1 : sclk0, 1);
    chk({nm, "_mosi"},   sel ? mosi1 : mosi0, 0);
    chk({nm, "_busy"},   sel ? busy1 : busy0, 0);
    chk({nm, "_done"},   sel ? done1 : done0, 0);
  endtask

  // Issue one start, optionally poke a stray start at cycle 50, and measure
  // busy length and done pulses. Returns in the first busy=0 cycle.
  task automatic run_frame(input bit sel, input logic [W-1:0] w, input bit inj,
                           output int blen, output int dn);
    int cyc;
    bit fin;
    blen = 0; dn = 0; cyc = 0; fin = 1'b0;
    if (sel) begin start1 = 1'b1; data1 = w; end
    else     begin start0 = 1'b1; data0 = w; end
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0;
    data0 = W'($urandom); data1 = W'($urandom);
    chk("accept_busy",   sel ? busy1 : busy0, 1);
    chk("accept_sync_n", sel ? sync1 : sync0, 0);
    chk("accept_mosi",   sel ? mosi1 : mosi0, w[W-1]);
    while (!fin && cyc < 2000) begin
      if (sel ? busy1 : busy0) blen++;
      else fin = 1'b1;
      if (sel ? done1 : done0) dn++;
      if (!fin) begin
        if (inj && cyc == 50) begin
          if (sel) begin start1 = 1'b1; data1 = '1; end
          else     begin start0 = 1'b1; data0 = '1; end
        end else begin
          start0 = 1'b0; start1 = 1'b0;
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    chk("busy_timeout", fin, 1);
    chk("done_at_busy_fall", sel ? done1 : done0, 1);
  endtask

  typedef struct {
    bit           sel;
    logic [W-1:0] word;
    bit           inj;
  } vec_t;

  vec_t tbl [NVEC];

  initial begin
    int blen, dn, fb, fb1;
    logic [W-1:0] w;

    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; data0 = '0; data1 = '0;
    repeat (3) @(posedge clk); #1;
    chk_idle("reset0", 1'b0);
    chk_idle("reset1", 1'b1);
    rst = 1'b0;
    @(negedge clk); #1;
    fb = frames[0]; fb1 = frames[1];
    repeat (20) @(posedge clk); #1;
    chk("no_activity_frames0", frames[0], fb);
    chk("no_activity_frames1", frames[1], fb1);
    chk_idle("post_reset0", 1'b0);

    tbl[0] = '{1'b0, 24'hA5C30F, 1'b0};
    tbl[1] = '{1'b0, 24'hA5C30F, 1'b1};
    tbl[2] = '{1'b0, DAC_CMD_SOFT_RESET, 1'b0};
    tbl[3] = '{1'b0, DAC_CMD_VREF_INT, 1'b0};
    tbl[4] = '{1'b1, 24'h000001, 1'b0};
    for (int i = 5; i < NVEC; i++)
      tbl[i] = '{bit'(i % 2), W'($urandom), bit'(i == 7)};

    for (int i = 0; i < NVEC; i++) begin
      fb = frames[tbl[i].sel];
      run_frame(tbl[i].sel, tbl[i].word, tbl[i].inj, blen, dn);
      @(negedge clk); #1;
      chk($sformatf("v%0d_busy_len", i), blen, model_busy(tbl[i].sel));
      chk($sformatf("v%0d_done_cnt", i), dn, 1);
      chk($sformatf("v%0d_frames", i), frames[tbl[i].sel], fb + 1);
      chk($sformatf("v%0d_word", i), last_word[tbl[i].sel], tbl[i].word);
      chk($sformatf("v%0d_bits", i), last_bits[tbl[i].sel], W);
      chk($sformatf("v%0d_sclk_period", i),
          t_fall[tbl[i].sel] - t_fall_prev[tbl[i].sel], 2 * cd_of(tbl[i].sel) * CLK_P);
      if (i == 3)
        chk_true("b2b_gap", gap_seen[0] >= MEMS_GAP_CYCLES, gap_seen[0]);
      if (i == 4)
        chk("last_bit_one", last_word[1][0], 1);
      // run_frame returns in a busy=0 cycle, so the next vector's start
      // lands on the earliest acceptable IDLE cycle (back-to-back).
    end

    // Reset in the middle of a frame
    fb = frames[0];
    start0 = 1'b1; data0 = 24'h5A5A5A;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (99) @(posedge clk); #1;
    chk("mid_frame_sync_low", sync0, 0);
    rst = 1'b1;
    #1;
    chk_idle("async_reset0", 1'b0);
    @(negedge clk); #1;
    chk("abort_frames", frames[0], fb + 1);
    chk_true("abort_incomplete", last_bits[0] < W, last_bits[0]);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    fb = frames[0];
    w = W'($urandom);
    run_frame(1'b0, w, 1'b0, blen, dn);
    @(negedge clk); #1;
    chk("after_reset_busy_len", blen, model_busy(1'b0));
    chk("after_reset_done_cnt", dn, 1);
    chk("after_reset_frames", frames[0], fb + 1);
    chk("after_reset_word", last_word[0], w);
    chk("after_reset_bits", last_bits[0], W);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
